// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//
// Multi-read-port, dual-write-port integer register file with a per-register
// busy scoreboard. Register 0 is hardwired to zero and never busy.
//
// Parameters
//   XLEN   data width of every register and data port
//   NREGS  number of architectural registers (power of two, >= 2)
//   NREAD  number of independent combinational read ports (1..4)
//   AW     derived register-index width, log2(NREGS)
//
// Ports
//   clk         single clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   rd_idx      packed read indices, port k at [k*AW +: AW]
//   rd_data     packed read data, port k at [k*XLEN +: XLEN]
//   rd_busy     bit k high when register rd_idx[k] has a pending producer
//   we0/we1     write enables for write ports 0 and 1
//   wa0/wa1     write indices
//   wd0/wd1     write data
//   alloc_en    mark register alloc_idx busy at the next edge
//   alloc_idx   register to mark busy
//   busy_count  registered population count of the busy bits
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NREAD = 2,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD*AW-1:0]   rd_idx,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  we0,
    input  logic [AW-1:0]         wa0,
    input  logic [XLEN-1:0]       wd0,
    input  logic                  we1,
    input  logic [AW-1:0]         wa1,
    input  logic [XLEN-1:0]       wd1,
    input  logic                  alloc_en,
    input  logic [AW-1:0]         alloc_idx,
    output logic [AW:0]           busy_count
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      busy_count_q;
    logic [AW:0]      busy_count_d;

    // Per-register decoded write/alloc strobes (index 0 never asserted).
    logic [NREGS-1:0] wr_hit;
    logic [NREGS-1:0] alloc_hit;
    logic [XLEN-1:0]  wr_data [NREGS];

    // -------------------------------------------------------------------------
    // Write / alloc decode
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < int'(NREGS); i++) begin
            logic hit0;
            logic hit1;
            hit0         = we0 && (wa0 == AW'(i)) && (i != 0);
            hit1         = we1 && (wa1 == AW'(i)) && (i != 0);
            wr_hit[i]    = hit0 || hit1;
            // Port 1 wins a same-index conflict; port 0's data is dropped.
            wr_data[i]   = hit1 ? wd1 : wd0;
            alloc_hit[i] = alloc_en && (alloc_idx == AW'(i)) && (i != 0);
        end
    end

    // -------------------------------------------------------------------------
    // Scoreboard next state: a write retires the producer, but an alloc in
    // the same cycle issues a new one, so alloc is applied last.
    // -------------------------------------------------------------------------
    always_comb begin
        busy_d       = (busy_q & ~wr_hit) | alloc_hit;
        busy_count_d = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            busy_count_d = busy_count_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            for (int i = 0; i < int'(NREGS); i++) begin
                if (wr_hit[i]) begin
                    regs_q[i] <= wr_data[i];
                end
            end
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign busy_count = busy_count_q;

    // -------------------------------------------------------------------------
    // Read ports: combinational with same-cycle write bypass. Bypass does not
    // look at rst so a concurrent write is still forwarded during reset.
    // -------------------------------------------------------------------------
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < int'(NREAD); k++) begin
            logic [AW-1:0]   idx;
            logic [XLEN-1:0] data;
            logic            busy;
            idx = rd_idx[k*AW +: AW];
            if (idx == '0) begin
                data = '0;
            end else if (we1 && (wa1 == idx)) begin
                data = wd1;
            end else if (we0 && (wa0 == idx)) begin
                data = wd0;
            end else begin
                data = regs_q[idx];
            end
            // A register being written this cycle is no longer waiting on its
            // producer, unless a new producer is allocated in the same cycle.
            if (idx == '0) begin
                busy = 1'b0;
            end else if (wr_hit[idx]) begin
                busy = alloc_hit[idx];
            end else begin
                busy = busy_q[idx];
            end
            rd_data[k*XLEN +: XLEN] = data;
            rd_busy[k]              = busy;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
//
// Scoreboard bench for regfile_mp built with NREAD=4, NREGS=16. Stimulus is
// applied just after each rising edge and the expected port values for that
// cycle are queued; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 16;
    localparam int NREAD = 4;
    localparam int AW    = 4;

    logic                  clk;
    logic                  rst;
    logic [NREAD*AW-1:0]   rd_idx;
    logic [NREAD*XLEN-1:0] rd_data;
    logic [NREAD-1:0]      rd_busy;
    logic                  we0;
    logic [AW-1:0]         wa0;
    logic [XLEN-1:0]       wd0;
    logic                  we1;
    logic [AW-1:0]         wa1;
    logic [XLEN-1:0]       wd1;
    logic                  alloc_en;
    logic [AW-1:0]         alloc_idx;
    logic [AW:0]           busy_count;

    regfile_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NREAD (NREAD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .we0        (we0),
        .wa0        (wa0),
        .wd0        (wd0),
        .we1        (we1),
        .wa1        (wa1),
        .wd1        (wd1),
        .alloc_en   (alloc_en),
        .alloc_idx  (alloc_idx),
        .busy_count (busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string                          name;
        logic [NREAD-1:0][XLEN-1:0]     data;
        logic [NREAD-1:0]               busy;
        logic [AW:0]                    cnt;
    } exp_t;

    exp_t sb[$];
    bit   probe;
    int   checks;
    int   failures;

    // -------------------------------------------------------------------------
    // Monitor
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        if (probe) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL monitor: probe with empty scoreboard");
            end else begin
                exp_t e;
                e = sb.pop_front();
                for (int k = 0; k < NREAD; k++) begin
                    checks++;
                    if (rd_data[k*XLEN +: XLEN] !== e.data[k]) begin
                        failures++;
                        $display("FAIL %s rd_data[%0d]: got %h expected %h",
                                 e.name, k, rd_data[k*XLEN +: XLEN], e.data[k]);
                    end
                end
                checks++;
                if (rd_busy !== e.busy) begin
                    failures++;
                    $display("FAIL %s rd_busy: got %b expected %b", e.name, rd_busy, e.busy);
                end
                checks++;
                if (busy_count !== e.cnt) begin
                    failures++;
                    $display("FAIL %s busy_count: got %0d expected %0d",
                             e.name, busy_count, e.cnt);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic idle();
        rst       = 1'b0;
        we0       = 1'b0;
        wa0       = '0;
        wd0       = '0;
        we1       = 1'b0;
        wa1       = '0;
        wd1       = '0;
        alloc_en  = 1'b0;
        alloc_idx = '0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [AW-1:0] a2, input logic [AW-1:0] a3);
        rd_idx = {a3, a2, a1, a0};
    endtask

    // Queue the expectation for the inputs currently driven, then advance one
    // cycle and return the write/alloc/reset controls to idle.
    task automatic expect_cycle(input string name,
                                input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1,
                                input logic [XLEN-1:0] d2, input logic [XLEN-1:0] d3,
                                input logic [NREAD-1:0] b, input int c);
        exp_t e;
        e.name = name;
        e.data = {d3, d2, d1, d0};
        e.busy = b;
        e.cnt  = (AW+1)'(c);
        sb.push_back(e);
        probe = 1'b1;
        @(posedge clk);
        #1;
        probe = 1'b0;
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        checks   = 0;
        failures = 0;
        probe    = 1'b0;
        idle();
        rst = 1'b1;
        set_rd(0, 0, 0, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        idle();

        // Reset state on every index
        set_rd(0, 1, 2, 3);
        expect_cycle("reset_lo", 0, 0, 0, 0, 4'b0000, 0);
        set_rd(15, 8, 5, 4);
        expect_cycle("reset_hi", 0, 0, 0, 0, 4'b0000, 0);

        // Bypass then storage, all four ports on x5
        set_rd(5, 5, 5, 5);
        we0 = 1'b1; wa0 = 5; wd0 = 32'hDEADBEEF;
        expect_cycle("x5_bypass", 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
                     4'b0000, 0);
        expect_cycle("x5_stored", 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
                     4'b0000, 0);

        // Write-port conflict on x7: port 1 wins
        set_rd(7, 7, 5, 0);
        we0 = 1'b1; wa0 = 7; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 7; wd1 = 32'h22;
        expect_cycle("x7_conflict", 32'h22, 32'h22, 32'hDEADBEEF, 0, 4'b0000, 0);
        expect_cycle("x7_stored", 32'h22, 32'h22, 32'hDEADBEEF, 0, 4'b0000, 0);

        // x0 write ignored
        set_rd(0, 0, 7, 0);
        we0 = 1'b1; wa0 = 0; wd0 = 32'hFFFFFFFF;
        expect_cycle("x0_write", 0, 0, 32'h22, 0, 4'b0000, 0);
        expect_cycle("x0_after", 0, 0, 32'h22, 0, 4'b0000, 0);

        // Alloc x3 then x4, then retire x3
        set_rd(3, 4, 0, 5);
        alloc_en = 1'b1; alloc_idx = 3;
        expect_cycle("alloc_x3", 0, 0, 0, 32'hDEADBEEF, 4'b0000, 0);
        alloc_en = 1'b1; alloc_idx = 4;
        expect_cycle("alloc_x4", 0, 0, 0, 32'hDEADBEEF, 4'b0001, 1);
        expect_cycle("busy_x3x4", 0, 0, 0, 32'hDEADBEEF, 4'b0011, 2);
        we0 = 1'b1; wa0 = 3; wd0 = 32'hAB;
        expect_cycle("write_x3", 32'hAB, 0, 0, 32'hDEADBEEF, 4'b0010, 2);
        expect_cycle("after_x3", 32'hAB, 0, 0, 32'hDEADBEEF, 4'b0010, 1);

        // Alloc and write x9 together: data stored, alloc wins the busy bit
        set_rd(9, 4, 3, 0);
        alloc_en = 1'b1; alloc_idx = 9;
        we1 = 1'b1; wa1 = 9; wd1 = 32'h55;
        expect_cycle("alloc_wr_x9", 32'h55, 0, 32'hAB, 0, 4'b0011, 1);
        expect_cycle("after_x9", 32'h55, 0, 32'hAB, 0, 4'b0011, 2);

        // Alloc x0 ignored, re-alloc busy x4 keeps count
        set_rd(0, 9, 4, 3);
        alloc_en = 1'b1; alloc_idx = 0;
        expect_cycle("alloc_x0", 0, 32'h55, 0, 32'hAB, 4'b0110, 2);
        alloc_en = 1'b1; alloc_idx = 4;
        expect_cycle("realloc_x4", 0, 32'h55, 0, 32'hAB, 4'b0110, 2);

        // Write non-busy x8 leaves count alone
        set_rd(8, 9, 4, 3);
        we0 = 1'b1; wa0 = 8; wd0 = 32'h1234;
        expect_cycle("write_x8", 32'h1234, 32'h55, 0, 32'hAB, 4'b0110, 2);
        alloc_en = 1'b1; alloc_idx = 3;
        expect_cycle("alloc_x3_again", 32'h1234, 32'h55, 0, 32'hAB, 4'b0110, 2);

        // Reset mid-operation with a concurrent write and alloc
        set_rd(6, 8, 3, 9);
        rst = 1'b1;
        we0 = 1'b1; wa0 = 6; wd0 = 32'h77;
        alloc_en = 1'b1; alloc_idx = 5;
        expect_cycle("rst_cycle", 32'h77, 32'h1234, 32'hAB, 32'h55, 4'b1100, 3);
        expect_cycle("post_rst", 0, 0, 0, 0, 4'b0000, 0);
        set_rd(5, 7, 8, 3);
        expect_cycle("post_rst2", 0, 0, 0, 0, 4'b0000, 0);

        @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d entries left expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, default 32, data width of every register and data port.
REQ-002 Parameter NREGS, default 32, number of architectural registers; power of two, >= 2.
REQ-003 Parameter NREAD, default 2, number of independent read ports, 1..4.
REQ-004 Derived localparam AW = log2(NREGS), the width of a register index.
REQ-005 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset; one clock, reset is synchronous and active-high.
REQ-007 Port rd_idx, input, NREAD*AW: read indices; port k occupies bits [k*AW +: AW].
REQ-008 Port rd_data, output, NREAD*XLEN: read data; port k occupies bits [k*XLEN +: XLEN].
REQ-009 Port rd_busy, output, NREAD: bit k is high when register rd_idx[k] has a pending producer.
REQ-010 Ports we0/we1, input, 1 each: write enables for write ports 0 and 1.
REQ-011 Ports wa0/wa1, input, AW each: write indices.
REQ-012 Ports wd0/wd1, input, XLEN each: write data.
REQ-013 Port alloc_en, input, 1: marks register alloc_idx as busy (producer issued).
REQ-014 Port alloc_idx, input, AW: register to mark busy.
REQ-015 Port busy_count, output, AW+1: number of registers currently busy.

Function
REQ-016 Register 0 reads as 0 on every read port, is never written, and is never busy; alloc or write to index 0 is ignored.
REQ-017 Reads are combinational: rd_data[k] = current contents of rd_idx[k], with the bypass rule of REQ-019 applied.
REQ-018 Writes take effect at the rising clk edge when weN=1 and waN!=0; the new value is visible in storage from the next cycle.
REQ-019 Bypass: when a read index equals an enabled, non-zero write index in the same cycle, rd_data returns that write's wdN in the same cycle.
REQ-020 Write-port conflict: when we0 and we1 both target the same non-zero index, wd1 is stored and bypassed; wd0 is dropped.
REQ-021 Scoreboard: one busy bit per register; alloc_en=1 with alloc_idx!=0 sets the bit at the next edge.
REQ-022 An enabled write to a non-zero index clears that register's busy bit at the next edge.
REQ-023 Simultaneous alloc and write to the same index: the write stores data, and the busy bit ends set (alloc wins).
REQ-024 rd_busy[k] reflects the registered busy bit, with same-cycle forwarding: a read whose index is being written this cycle reports busy=0 unless alloc targets that index in the same cycle.
REQ-025 busy_count is registered and equals the population count of the busy bits after each edge; range 0..NREGS-1.
REQ-026 Alloc of an already-busy register keeps it busy; busy_count does not change.
REQ-027 Write to a non-busy register is legal; it stores data and leaves busy_count unchanged.
REQ-028 Read ports are independent; any number of ports may address the same register with identical results.

Reset
REQ-029 While rst=1 at a rising edge, all registers clear to 0, all busy bits clear, and busy_count becomes 0; writes and allocs in that cycle are discarded.
REQ-030 Reset mid-operation discards all pending busy state; after rst, every rd_data is 0 and every rd_busy is 0 (combinational bypass of a concurrent write still applies while rst is high).
REQ-031 The register file holds no undefined state after the first reset edge.

Verification
REQ-032 Reset then read all indices on all ports -> rd_data=0, rd_busy=0, busy_count=0.
REQ-033 Write 0xDEADBEEF to x5 via port 0; same cycle read x5 -> 0xDEADBEEF (bypass); next cycle read x5 -> 0xDEADBEEF from storage.
REQ-034 we0/we1 both to x7, wd0=0x11, wd1=0x22 -> same-cycle read 0x22; stored 0x22; write to x0 with 0xFFFFFFFF -> x0 reads 0.
REQ-035 Alloc x3, x4 on consecutive cycles -> busy_count 1 then 2, rd_busy set for both; write x3 -> busy_count 1, rd_busy(x3)=0 in the write cycle.
REQ-036 Alloc x9 and write x9=0x55 in the same cycle -> x9=0x55, busy(x9)=1, busy_count +1; alloc x0 -> no change.
REQ-037 With x3 busy and x8=0x1234, assert rst -> next cycle all data 0, busy_count=0; NREAD=4, NREGS=16 build repeats REQ-033 on all ports.
